// File: rtl/row_request_generator.sv
// -----------------------------------------------------------------------------
// row_request_generator
//
// Turns a start command plus a viewport description into one request packet
// per image row, emitted as a valid/ready word stream. Each packet is five
// words long and its last word is flagged with out_end_of_stream:
//   w0 = row index (zero-extended), w1 = cols, w2 = x0, w3 = y of this row,
//   w4 = dx (out_end_of_stream = 1)
// The y coordinate starts at cfg_y0 and advances by cfg_dy per row, wrapping
// modulo 2^WIDTH.
//
// Optional feature, enabled by defining ROW_GEN_ABORT_EN:
//   adds input 'abort'. Once seen in EMIT, no new packet is started; a packet
//   that is already presented still runs through its w4 transfer.
//
// Ports
//   clock, reset_n      clock and asynchronous active-low reset
//   start               command pulse, accepted only while busy = 0
//   cfg_x0, cfg_y0      coordinates of column 0 / row 0
//   cfg_dx, cfg_dy      step per column / per row
//   cfg_cols            columns per row, passed through in w1
//   cfg_rows            number of rows (packets) in the frame
//   abort               (ROW_GEN_ABORT_EN only) stop after the current packet
//   out_data            stream word
//   out_valid           out_data / out_end_of_stream are valid
//   out_end_of_stream   last word of a packet
//   out_ready           consumer accepts the current word
//   busy                frame in progress
//   done                one-cycle pulse when the frame completes
// -----------------------------------------------------------------------------
module row_request_generator #(
  parameter int WIDTH    = 32,
  parameter int ROW_BITS = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    cfg_x0,
  input  logic [WIDTH-1:0]    cfg_y0,
  input  logic [WIDTH-1:0]    cfg_dx,
  input  logic [WIDTH-1:0]    cfg_dy,
  input  logic [WIDTH-1:0]    cfg_cols,
  input  logic [ROW_BITS-1:0] cfg_rows,
`ifdef ROW_GEN_ABORT_EN
  input  logic                abort,
`endif
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  output logic                out_end_of_stream,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_WORD = 3'd4;

  state_t              state;

  // Frame configuration, captured on an accepted start so that cfg_* may
  // change freely while the frame runs.
  logic [WIDTH-1:0]    x0_q;
  logic [WIDTH-1:0]    dx_q;
  logic [WIDTH-1:0]    dy_q;
  logic [WIDTH-1:0]    cols_q;
  logic [ROW_BITS-1:0] rows_q;

  // Per-frame progress.
  logic [WIDTH-1:0]    y_acc;     // y of the row currently being emitted
  logic [ROW_BITS-1:0] row_q;     // index of the row currently being emitted
  logic [2:0]          word_idx;  // index of the word currently presented

  logic                accept;
  logic                xfer;
  logic                rows_reached;
  logic                abort_hit;
  logic [ROW_BITS-1:0] row_inc;
  logic [2:0]          word_next;

  // Start is honoured whenever busy is low, i.e. in IDLE and in DONE.
  assign accept       = start && (state == IDLE || state == DONE);
  assign xfer         = out_valid && out_ready;
  assign row_inc      = row_q + ROW_BITS'(1);
  assign rows_reached = (row_inc == rows_q);
  assign word_next    = word_idx + 3'd1;

`ifdef ROW_GEN_ABORT_EN
  logic abort_flag;
  // Include the live input so an abort arriving on the very edge of a w4
  // transfer already suppresses the next packet.
  assign abort_hit = abort_flag || abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Word presented at position idx of the current packet.
  function automatic logic [WIDTH-1:0] word_at(input logic [2:0] idx);
    logic [WIDTH-1:0] w;
    case (idx)
      3'd0:    w = WIDTH'(row_q);
      3'd1:    w = cols_q;
      3'd2:    w = x0_q;
      3'd3:    w = y_acc;
      default: w = dx_q;
    endcase
    return w;
  endfunction

  // NOTE: every register here, configuration included, has an async reset;
  // there is no storage array, so nothing is too large to clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      x0_q              <= '0;
      dx_q              <= '0;
      dy_q              <= '0;
      cols_q            <= '0;
      rows_q            <= '0;
      y_acc             <= '0;
      row_q             <= '0;
      word_idx          <= '0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_end_of_stream <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
`ifdef ROW_GEN_ABORT_EN
      abort_flag        <= 1'b0;
`endif
    end else if (accept) begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of the state it is updating.
      state             <= EMIT;
      x0_q              <= cfg_x0;
      dx_q              <= cfg_dx;
      dy_q              <= cfg_dy;
      cols_q            <= cfg_cols;
      rows_q            <= cfg_rows;
      y_acc             <= cfg_y0;
      row_q             <= '0;
      word_idx          <= '0;
      busy              <= 1'b1;
      done              <= 1'b0;
      // w0 of row 0 is simply zero. With zero rows nothing is presented and
      // the single EMIT cycle falls straight through to DONE.
      out_data          <= '0;
      out_valid         <= (cfg_rows != '0);
      out_end_of_stream <= 1'b0;
`ifdef ROW_GEN_ABORT_EN
      abort_flag        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
        end

        EMIT: begin
`ifdef ROW_GEN_ABORT_EN
          if (abort) abort_flag <= 1'b1;
`endif
          if (!out_valid) begin
            // No packet in flight: either the row budget is spent (rows = 0)
            // or an abort arrived before w0 was presented.
            if (row_q == rows_q || abort_hit) begin
              state             <= DONE;
              busy              <= 1'b0;
              done              <= 1'b1;
              out_data          <= '0;
              out_end_of_stream <= 1'b0;
            end else begin
              word_idx          <= '0;
              out_data          <= word_at(3'd0);
              out_valid         <= 1'b1;
              out_end_of_stream <= 1'b0;
            end
          end else if (xfer) begin
            if (word_idx != LAST_WORD) begin
              word_idx          <= word_next;
              out_data          <= word_at(word_next);
              out_end_of_stream <= (word_next == LAST_WORD);
            end else begin
              // Row finished: step y (plain wrap, no saturation) and the row.
              y_acc <= y_acc + dy_q;
              row_q <= row_inc;
              if (rows_reached || abort_hit) begin
                state             <= DONE;
                busy              <= 1'b0;
                done              <= 1'b1;
                out_valid         <= 1'b0;
                out_data          <= '0;
                out_end_of_stream <= 1'b0;
              end else begin
                // Next packet starts on the following cycle with no bubble.
                word_idx          <= '0;
                out_data          <= WIDTH'(row_inc);
                out_end_of_stream <= 1'b0;
              end
            end
          end
          // Stalled with out_valid high: hold data and flag unchanged.
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
`ifdef ROW_GEN_ABORT_EN
          abort_flag <= 1'b0;
`endif
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_request_generator.sv
// -----------------------------------------------------------------------------
// tb_row_request_generator
//
// Self-checking bench for row_request_generator. Expected words are pushed to
// a scoreboard queue from a reference frame model when a frame is started;
// words the DUT transfers are collected by drain() and popped against it.
// The abort scenario is compiled only when ROW_GEN_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_row_request_generator;

  localparam int WIDTH    = 32;
  localparam int ROW_BITS = 16;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                start;
  logic [WIDTH-1:0]    cfg_x0, cfg_y0, cfg_dx, cfg_dy, cfg_cols;
  logic [ROW_BITS-1:0] cfg_rows;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_end_of_stream;
  logic                out_ready;
  logic                busy;
  logic                done;
`ifdef ROW_GEN_ABORT_EN
  logic                abort;
`endif

  always #5 clock = ~clock;

  row_request_generator #(.WIDTH(WIDTH), .ROW_BITS(ROW_BITS)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .cfg_x0            (cfg_x0),
    .cfg_y0            (cfg_y0),
    .cfg_dx            (cfg_dx),
    .cfg_dy            (cfg_dy),
    .cfg_cols          (cfg_cols),
    .cfg_rows          (cfg_rows),
`ifdef ROW_GEN_ABORT_EN
    .abort             (abort),
`endif
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_end_of_stream (out_end_of_stream),
    .out_ready         (out_ready),
    .busy              (busy),
    .done              (done)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are {end_of_stream, data}.
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] obs_q[$];

  // Observations gathered by drain().
  int done_cnt;
  int done_cyc;
  int stab_err;
  bit valid_seen;
  bit busy_c1;
  bit busy_at_done;

  // Reference model: expected packet words for a whole frame.
  task automatic push_frame(input int rows, input logic [31:0] x0, input logic [31:0] y0,
                            input logic [31:0] dx, input logic [31:0] dy,
                            input logic [31:0] cols);
    logic [31:0] y;
    y = y0;
    for (int r = 0; r < rows; r++) begin
      exp_q.push_back({1'b0, 32'(r)});
      exp_q.push_back({1'b0, cols});
      exp_q.push_back({1'b0, x0});
      exp_q.push_back({1'b0, y});
      exp_q.push_back({1'b1, dx});
      y = y + dy;
    end
  endtask

  // Entered and left at posedge+1. Presents cfg with start for one edge.
  task automatic start_frame(input logic [15:0] rows, input logic [31:0] x0,
                             input logic [31:0] y0, input logic [31:0] dx,
                             input logic [31:0] dy, input logic [31:0] cols);
    cfg_rows = rows; cfg_x0 = x0; cfg_y0 = y0; cfg_dx = dx; cfg_dy = dy; cfg_cols = cols;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Runs the stream after start_frame; cycle 1 is the cycle after the start
  // edge. Collects transfers and bookkeeping only, no comparisons.
  //   pulse_cyc: cycle in which start is re-pulsed with a different cfg
  //   abort_cyc: cycle in which out_ready is forced low (and abort raised)
  task automatic drain(input int max_cyc, input bit rand_ready,
                       input int pulse_cyc, input int abort_cyc);
    bit             prev_stall;
    logic [WIDTH:0] prev_word;
    int             nxt;
    obs_q.delete();
    done_cnt = 0; done_cyc = -1; stab_err = 0; valid_seen = 0;
    busy_c1 = 0; busy_at_done = 1; prev_stall = 0; prev_word = '0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clock);
      if (prev_stall && !(out_valid && {out_end_of_stream, out_data} == prev_word))
        stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_end_of_stream, out_data};
      if (out_valid) valid_seen = 1;
      if (out_valid && out_ready) obs_q.push_back({out_end_of_stream, out_data});
      if (cyc == 1) busy_c1 = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          busy_at_done = busy;
        end
      end
      @(posedge clock);
      #1;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      nxt = cyc + 1;
      out_ready = (nxt == abort_cyc) ? 1'b0 :
                  (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      start = (nxt == pulse_cyc);
      if (nxt == pulse_cyc) begin
        cfg_rows = 16'd5; cfg_x0 = 32'hDEAD_0000; cfg_y0 = 32'h1234;
        cfg_dx = 32'd7; cfg_dy = 32'd9; cfg_cols = 32'd3;
      end
`ifdef ROW_GEN_ABORT_EN
      abort = (nxt == abort_cyc);
`endif
    end
    start     = 1'b0;
    out_ready = 1'b1;
`ifdef ROW_GEN_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total++;
    if ({out_data, out_valid, out_end_of_stream, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h v=%b eos=%b busy=%b done=%b expected all 0",
               out_data, out_valid, out_end_of_stream, busy, done);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if ({out_data, out_valid, out_end_of_stream, busy, done} !== '0) begin
      bad++;
      $display("FAIL idle_after_reset: got data=%h v=%b eos=%b busy=%b done=%b expected all 0",
               out_data, out_valid, out_end_of_stream, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH:0] e, o;
    int             i;
    out_ready = 1'b1;
    push_frame(3, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    start_frame(16'd3, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    drain(60, 1'b0, 0, 0);
    total++;
    if (obs_q.size() !== 15) begin
      bad++; $display("FAIL basic_count: got %0d words expected 15", obs_q.size());
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL basic_word%0d: got %h expected %h", i, o, e);
      end
      i++;
    end
    total++;
    if (done_cyc !== 16) begin
      bad++; $display("FAIL basic_done_cycle: got %0d expected 16", done_cyc);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
    total++;
    if (busy_c1 !== 1'b1) begin
      bad++; $display("FAIL basic_busy_first: got %b expected 1", busy_c1);
    end
    total++;
    if (busy_at_done !== 1'b0) begin
      bad++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done);
    end
  endtask

  task automatic test_random_ready();
    logic [WIDTH:0] e, o;
    int             i;
    out_ready = 1'($urandom_range(0, 1));
    push_frame(3, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    start_frame(16'd3, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    drain(400, 1'b1, 0, 0);
    total++;
    if (obs_q.size() !== 15) begin
      bad++; $display("FAIL random_count: got %0d words expected 15", obs_q.size());
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL random_word%0d: got %h expected %h", i, o, e);
      end
      i++;
    end
    total++;
    if (stab_err !== 0) begin
      bad++; $display("FAIL random_stall_stable: got %0d unstable stalls expected 0", stab_err);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL random_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH:0] e, o;
    int             i;
    out_ready = 1'b1;
    push_frame(2, 32'h40, 32'h7FFF_FFFF, 32'd2, 32'd1, 32'd9);
    start_frame(16'd2, 32'h40, 32'h7FFF_FFFF, 32'd2, 32'd1, 32'd9);
    drain(60, 1'b0, 0, 0);
    o = (obs_q.size() > 8) ? obs_q[8] : 'x;
    total++;
    if (o !== {1'b0, 32'h8000_0000}) begin
      bad++; $display("FAIL wrap_row1_y: got %h expected 0_80000000", o);
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL wrap_word%0d: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_zero_rows();
    out_ready = 1'b1;
    start_frame(16'd0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
    drain(20, 1'b0, 0, 0);
    total++;
    if (valid_seen !== 1'b0) begin
      bad++; $display("FAIL zero_no_valid: got valid_seen=%b expected 0", valid_seen);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt);
    end
    total++;
    if (done_cyc !== 2) begin
      bad++; $display("FAIL zero_done_cycle: got %0d expected 2", done_cyc);
    end
    total++;
    if (busy_c1 !== 1'b1) begin
      bad++; $display("FAIL zero_busy_first: got %b expected 1", busy_c1);
    end
  endtask

  task automatic test_restart_and_reset();
    logic [WIDTH:0] e, o;
    int             i;
    // Re-pulsed start mid-frame with another config must be ignored.
    out_ready = 1'b1;
    push_frame(3, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    start_frame(16'd3, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    drain(60, 1'b0, 4, 0);
    total++;
    if (obs_q.size() !== 15) begin
      bad++; $display("FAIL restart_count: got %0d words expected 15", obs_q.size());
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL restart_word%0d: got %h expected %h", i, o, e);
      end
      i++;
    end
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt);
    end

    // Reset while w2 of row 1 is on the bus.
    start_frame(16'd3, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    for (int c = 1; c <= 8; c++) @(negedge clock);
    total++;
    if ({out_valid, out_end_of_stream, out_data} !== {2'b10, 32'h100}) begin
      bad++; $display("FAIL pre_reset_w2: got v=%b eos=%b data=%h expected v=1 eos=0 data=00000100",
                      out_valid, out_end_of_stream, out_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({out_data, out_valid, out_end_of_stream, busy, done} !== '0) begin
      bad++; $display("FAIL midframe_reset: got data=%h v=%b eos=%b busy=%b done=%b expected all 0",
                      out_data, out_valid, out_end_of_stream, busy, done);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    push_frame(1, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    start_frame(16'd1, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    drain(40, 1'b0, 0, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL after_reset_word%0d: got %h expected %h", i, o, e);
      end
      i++;
    end
    total++;
    if (done_cyc !== 6) begin
      bad++; $display("FAIL after_reset_done_cycle: got %0d expected 6", done_cyc);
    end
  endtask

`ifdef ROW_GEN_ABORT_EN
  task automatic test_abort();
    logic [WIDTH:0] e, o;
    int             i;
    out_ready = 1'b1;
    // Only rows 0 and 1 may appear: abort lands while row 1 w2 is stalled.
    push_frame(2, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    start_frame(16'd4, 32'h100, 32'h200, 32'd4, 32'd8, 32'd16);
    drain(80, 1'b0, 0, 8);
    total++;
    if (obs_q.size() !== 10) begin
      bad++; $display("FAIL abort_count: got %0d words expected 10", obs_q.size());
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL abort_word%0d: got %h expected %h", i, o, e);
      end
      i++;
    end
    total++;
    if (done_cyc !== 12) begin
      bad++; $display("FAIL abort_done_cycle: got %0d expected 12", done_cyc);
    end
    total++;
    if (stab_err !== 0) begin
      bad++; $display("FAIL abort_stall_stable: got %0d expected 0", stab_err);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_dx = '0; cfg_dy = '0; cfg_cols = '0; cfg_rows = '0;
`ifdef ROW_GEN_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_random_ready();
    test_wrap();
    test_zero_rows();
    test_restart_and_reset();
`ifdef ROW_GEN_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
